mist1032isa_fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of an asynchronous FIFO among REQ requesters in the write-clock domain. It holds one registered output beat and stalls it while the FIFO reports full, so no beat is dropped. It optionally locks the grant for multi-beat packets. It also passes a flush request through to the FIFO.

---
 rtl/mist1032isa_fifo_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_mist1032isa_fifo_wr_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mist1032isa_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among REQ requesters, with a
// registered, full-stalled output beat. Packet grant locking: MIST1032ISA_FIFO_WR_ARBITER_LOCK_EN.
module mist1032isa_fifo_wr_arbiter #(
  parameter int N     = 16,
  parameter int REQ   = 4,
  parameter int REQ_N = 2
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iREMOVE,
  input  logic [REQ-1:0]   iREQ_VALID,
  input  logic [REQ-1:0]   iREQ_LAST,
  input  logic [REQ*N-1:0] iREQ_DATA,
  output logic [REQ-1:0]   oREQ_BUSY,
  output logic             oFIFO_WR_EN,
  output logic [N-1:0]     oFIFO_WR_DATA,
  input  logic             iFIFO_WR_FULL,
  output logic             oFIFO_REMOVE
);

`ifdef MIST1032ISA_FIFO_WR_ARBITER_LOCK_EN
  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [REQ_N-1:0] b_owner_q, b_owner_d;
`else
  // Packet boundaries are irrelevant when every beat is arbitrated on its own.
  logic unused_last;
  assign unused_last = ^iREQ_LAST;
`endif

  logic             b_valid_q, b_valid_d;
  logic [N-1:0]     b_data_q, b_data_d;
  logic [REQ_N-1:0] b_ptr_q, b_ptr_d;

  logic             load_ok;
  logic             accept;
  logic             pkt_end;
  logic [REQ-1:0]   eligible;
  logic [REQ-1:0]   grant;
  logic [REQ_N-1:0] grant_idx;
  logic             grant_found;
  logic [REQ_N-1:0] cand;
  logic [REQ_N-1:0] next_ptr;

  assign load_ok = !b_valid_q || !iFIFO_WR_FULL;

`ifdef MIST1032ISA_FIFO_WR_ARBITER_LOCK_EN
  // While a packet is open only its owner may load, so an idle owner leaves a bubble.
  assign eligible = (state_q == S_LOCK) ? (iREQ_VALID & (REQ'(1) << b_owner_q)) : iREQ_VALID;
  assign pkt_end  = iREQ_LAST[grant_idx];
`else
  assign eligible = iREQ_VALID;
  assign pkt_end  = 1'b1;
`endif

  // NOTE: every variable written here gets a default first, so no path leaves one
  // unassigned and no latch can be inferred.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 0; k < REQ; k++) begin
      cand = REQ_N'((int'(b_ptr_q) + k) % REQ);
      if (!grant_found && eligible[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_found = 1'b1;
      end
    end
  end

  assign accept   = grant_found && load_ok && !iREMOVE;
  assign next_ptr = REQ_N'((int'(grant_idx) + 1) % REQ);

  assign oREQ_BUSY     = iREMOVE ? {REQ{1'b1}} : ~(grant & {REQ{load_ok}});
  assign oFIFO_WR_EN   = b_valid_q;
  assign oFIFO_WR_DATA = b_data_q;
  assign oFIFO_REMOVE  = iREMOVE;

  always_comb begin
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_ptr_d   = b_ptr_q;
`ifdef MIST1032ISA_FIFO_WR_ARBITER_LOCK_EN
    state_d   = state_q;
    b_owner_d = b_owner_q;
`endif
    if (iREMOVE) begin
      b_valid_d = 1'b0;
      b_ptr_d   = '0;
`ifdef MIST1032ISA_FIFO_WR_ARBITER_LOCK_EN
      state_d   = S_IDLE;
`endif
    end else if (accept) begin
      // A new beat may overwrite the one the FIFO takes on this same edge.
      b_valid_d = 1'b1;
      b_data_d  = iREQ_DATA[int'(grant_idx)*N +: N];
      if (pkt_end) begin
        b_ptr_d = next_ptr;
      end
`ifdef MIST1032ISA_FIFO_WR_ARBITER_LOCK_EN
      if (state_q == S_IDLE && !pkt_end) begin
        state_d   = S_LOCK;
        b_owner_d = grant_idx;
      end else if (state_q == S_LOCK && pkt_end) begin
        state_d   = S_IDLE;
      end
`endif
    end else if (!iFIFO_WR_FULL) begin
      b_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_valid_q <= 1'b0;
      // NOTE: the data register is reset too, because oFIFO_WR_DATA must read zero
      // out of reset rather than an undefined value.
      b_data_q  <= '0;
      b_ptr_q   <= '0;
`ifdef MIST1032ISA_FIFO_WR_ARBITER_LOCK_EN
      state_q   <= S_IDLE;
      b_owner_q <= '0;
`endif
    end else begin
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_ptr_q   <= b_ptr_d;
`ifdef MIST1032ISA_FIFO_WR_ARBITER_LOCK_EN
      state_q   <= state_d;
      b_owner_q <= b_owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_mist1032isa_fifo_wr_arbiter.sv
// Directed self-checking bench for mist1032isa_fifo_wr_arbiter: reset, round robin,
// full stall, packet lock (both builds of MIST1032ISA_FIFO_WR_ARBITER_LOCK_EN) and flush.
module tb_mist1032isa_fifo_wr_arbiter;
  localparam int N   = 16;
  localparam int REQ = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             remove;
  logic [REQ-1:0]   req_valid;
  logic [REQ-1:0]   req_last;
  logic [REQ*N-1:0] req_data;
  logic [REQ-1:0]   req_busy;
  logic             wr_en;
  logic [N-1:0]     wr_data;
  logic             wr_full;
  logic             fifo_remove;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] wlog[$];

  mist1032isa_fifo_wr_arbiter #(.N(N), .REQ(REQ), .REQ_N(2)) dut (
    .iCLOCK        (clk),
    .inRESET       (rst_n),
    .iREMOVE       (remove),
    .iREQ_VALID    (req_valid),
    .iREQ_LAST     (req_last),
    .iREQ_DATA     (req_data),
    .oREQ_BUSY     (req_busy),
    .oFIFO_WR_EN   (wr_en),
    .oFIFO_WR_DATA (wr_data),
    .iFIFO_WR_FULL (wr_full),
    .oFIFO_REMOVE  (fifo_remove)
  );

  always #5 clk = ~clk;

  // Beats actually consumed by the FIFO, as it would see them on the edge.
  always @(posedge clk) begin
    if (rst_n && wr_en && !wr_full) wlog.push_back(wr_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [N-1:0] d);
    req_valid[i]        = v;
    req_last[i]         = l;
    req_data[i*N +: N]  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    remove    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wr_full   = 1'b0;
    #3;
    check("reset_wr_en", 32'(wr_en), 32'h0);
    check("reset_wr_data", 32'(wr_data), 32'h0);
    check("reset_busy", 32'(req_busy), 32'hF);
    check("reset_remove", 32'(fifo_remove), 32'h0);
    #5 rst_n = 1'b1;
    tick();

    // Round robin: four single-beat packets, pointer starts at 0.
    for (int i = 0; i < REQ; i++) set_req(i, 1'b1, 1'b1, 16'hA000 + 16'(i));
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_busy%0d", k), 32'(req_busy), 32'(~(4'b0001 << (k % 4)) & 4'hF));
      tick();
      check($sformatf("rr_wr_en%0d", k), 32'(wr_en), 32'h1);
      check($sformatf("rr_data%0d", k), 32'(wr_data), 32'hA000 + 32'(k % 4));
    end
    req_valid = '0;
    #1;
    check("rr_idle_busy", 32'(req_busy), 32'hF);
    tick();
    check("rr_drain_wr_en", 32'(wr_en), 32'h0);
    check("rr_log_size", 32'(wlog.size()), 32'd5);
    check("rr_log4", 32'(wlog[4]), 32'hA000);
    check("rr_log3", 32'(wlog[3]), 32'hA003);

    // Full stall: pointer is 1, only req0 valid so it wins after the wrap.
    wlog.delete();
    set_req(0, 1'b1, 1'b1, 16'h1234);
    #1;
    check("full_load_busy", 32'(req_busy), 32'hE);
    tick();
    check("full_loaded", 32'(wr_data), 32'h1234);
    set_req(0, 1'b1, 1'b1, 16'h5678);
    wr_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("full_busy%0d", k), 32'(req_busy), 32'hF);
      tick();
      check($sformatf("full_wr_en%0d", k), 32'(wr_en), 32'h1);
      check($sformatf("full_hold%0d", k), 32'(wr_data), 32'h1234);
    end
    check("full_no_write", 32'(wlog.size()), 32'd0);
    wr_full = 1'b0;
    #1;
    check("unfull_busy", 32'(req_busy), 32'hE);
    tick();
    check("unfull_next", 32'(wr_data), 32'h5678);
    check("unfull_log_size", 32'(wlog.size()), 32'd1);
    check("unfull_log0", 32'(wlog[0]), 32'h1234);
    set_req(0, 1'b0, 1'b0, 16'h0);
    #1;
    tick();
    check("unfull_drain", 32'(wr_en), 32'h0);
    check("unfull_log1", 32'(wlog[1]), 32'h5678);

    // Packet from req1 (0x11,gap,0x12,0x13) against a persistent req2; pointer is 1.
    wlog.delete();
    set_req(2, 1'b1, 1'b1, 16'h0022);
`ifdef MIST1032ISA_FIFO_WR_ARBITER_LOCK_EN
    set_req(1, 1'b1, 1'b0, 16'h0011); #1; check("lk_b1_busy", 32'(req_busy), 32'hD); tick();
    set_req(1, 1'b0, 1'b0, 16'h0011); #1; check("lk_gap_busy", 32'(req_busy), 32'hF); tick();
    set_req(1, 1'b1, 1'b0, 16'h0012); #1; check("lk_b2_busy", 32'(req_busy), 32'hD); tick();
    set_req(1, 1'b1, 1'b1, 16'h0013); #1; check("lk_b3_busy", 32'(req_busy), 32'hD); tick();
    set_req(1, 1'b0, 1'b0, 16'h0000); #1; check("lk_r2_busy", 32'(req_busy), 32'hB); tick();
    set_req(2, 1'b0, 1'b0, 16'h0000); #1; check("lk_end_busy", 32'(req_busy), 32'hF); tick();
    check("lk_log_size", 32'(wlog.size()), 32'd4);
    check("lk_log0", 32'(wlog[0]), 32'h11);
    check("lk_log1", 32'(wlog[1]), 32'h12);
    check("lk_log2", 32'(wlog[2]), 32'h13);
    check("lk_log3", 32'(wlog[3]), 32'h22);
`else
    set_req(1, 1'b1, 1'b0, 16'h0011); #1; check("rr_b1_busy", 32'(req_busy), 32'hD); tick();
    set_req(1, 1'b0, 1'b0, 16'h0011); #1; check("rr_gap_busy", 32'(req_busy), 32'hB); tick();
    set_req(1, 1'b1, 1'b0, 16'h0012); #1; check("rr_b2_busy", 32'(req_busy), 32'hD); tick();
    set_req(1, 1'b1, 1'b1, 16'h0013); #1; check("rr_r2_busy", 32'(req_busy), 32'hB); tick();
    #1; check("rr_b3_busy", 32'(req_busy), 32'hD); tick();
    set_req(1, 1'b0, 1'b0, 16'h0000);
    set_req(2, 1'b0, 1'b0, 16'h0000); #1; check("rr_end_busy", 32'(req_busy), 32'hF); tick();
    check("il_log_size", 32'(wlog.size()), 32'd5);
    check("il_log0", 32'(wlog[0]), 32'h11);
    check("il_log1", 32'(wlog[1]), 32'h22);
    check("il_log2", 32'(wlog[2]), 32'h12);
    check("il_log3", 32'(wlog[3]), 32'h22);
    check("il_log4", 32'(wlog[4]), 32'h13);
`endif

    // Flush mid-packet with a stalled beat; afterwards req0 must win from pointer 0.
    wlog.delete();
    set_req(2, 1'b1, 1'b0, 16'h0033);
    #1;
    check("fl_open_busy", 32'(req_busy), 32'hB);
    tick();
    wr_full = 1'b1;
    set_req(0, 1'b1, 1'b1, 16'h000A);
    set_req(2, 1'b1, 1'b0, 16'h0034);
    set_req(3, 1'b1, 1'b1, 16'h0044);
    #1;
    check("fl_stall_busy", 32'(req_busy), 32'hF);
    tick();
    check("fl_stall_wr_en", 32'(wr_en), 32'h1);
    check("fl_stall_data", 32'(wr_data), 32'h33);
    remove = 1'b1;
    #1;
    check("fl_remove_out", 32'(fifo_remove), 32'h1);
    check("fl_remove_busy", 32'(req_busy), 32'hF);
    tick();
    check("fl_cleared", 32'(wr_en), 32'h0);
    remove  = 1'b0;
    wr_full = 1'b0;
    #1;
    check("fl_remove_low", 32'(fifo_remove), 32'h0);
    check("fl_req0_wins", 32'(req_busy), 32'hE);
    tick();
    check("fl_req0_data", 32'(wr_data), 32'h0A);
    req_valid = '0;
    #1;
    tick();
    check("fl_final_wr_en", 32'(wr_en), 32'h0);
    check("fl_log_size", 32'(wlog.size()), 32'd1);
    check("fl_log0", 32'(wlog[0]), 32'h0A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
